// File: rtl/core_pkg.sv
// Shared encodings for the register-bank datapath: arbiter state codes (also
// decoded by the 7-segment display) and the default bank word/address widths.
package core_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_ACK   = 2'd2,
        ARB_CLEAR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bank_wr_arbiter.sv
// Round-robin arbiter for the register bank's single write port: port 0 is the
// core write-back path, port 1 the debug/load port, each on a four-phase req/ack.
module bank_wr_arbiter
    import core_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    output logic          bank_we,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_data,
    output logic          busy,
    output logic [1:0]    state_out
);

    arb_state_e    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          win;
    logic          req_gnt;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign win     = (req0 && req1) ? ~last_q : req1;
    assign req_gnt = gnt_q ? req1 : req0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = win;
                    addr_d  = win ? addr1 : addr0;
                    data_d  = win ? data1 : data0;
                    state_d = ARB_WRITE;
                end
            end
            ARB_WRITE: state_d = ARB_ACK;
            ARB_ACK: begin
                if (!req_gnt) begin
                    last_d  = gnt_q;
                    state_d = ARB_CLEAR;
                end
            end
            ARB_CLEAR: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        we_d   = (state_d == ARB_WRITE);
        ack0_d = (state_d == ARB_ACK) && !gnt_d;
        ack1_d = (state_d == ARB_ACK) && gnt_d;
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign bank_we   = we_q;
    assign bank_addr = addr_q;
    assign bank_data = data_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_bank_wr_arbiter.sv
// Directed and randomized bench for bank_wr_arbiter against a transaction-phase
// reference model; every output is compared on every cycle.
module tb_bank_wr_arbiter;

    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          ack0, ack1, bank_we, busy;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_data;
    logic [1:0]    state_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase of the current transaction (0 none, 1 write,
    // 2 acknowledging, 3 dead cycle), its port, and the last port served.
    int            m_phase = 0;
    int            m_port  = 0;
    int            m_last  = 1;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    int   grants[$];
    logic pa0, pa1;

    bank_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data),
        .busy(busy), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ack(input int i);
        return (m_phase == 2) && (m_port == i);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_port  = 0;
        m_last  = 1;
        m_addr  = '0;
        m_data  = '0;
    endtask

    // Advance the model by one clock using the inputs the DUT samples at that edge.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (req0 || req1) begin
                    if (req0 && req1) m_port = 1 - m_last;
                    else              m_port = req1 ? 1 : 0;
                    m_addr  = (m_port == 1) ? addr1 : addr0;
                    m_data  = (m_port == 1) ? data1 : data0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: if (!((m_port == 1) ? req1 : req0)) begin
                    m_last  = m_port;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bank_we"},   32'(bank_we),   32'(m_phase == 1));
        chk({tag, ".bank_addr"}, 32'(bank_addr), 32'(m_addr));
        chk({tag, ".bank_data"}, 32'(bank_data), 32'(m_data));
        chk({tag, ".ack0"},      32'(ack0),      32'(exp_ack(0)));
        chk({tag, ".ack1"},      32'(ack1),      32'(exp_ack(1)));
        chk({tag, ".busy"},      32'(busy),      32'(m_phase != 0));
        chk({tag, ".state_out"}, 32'(state_out), 32'(m_phase));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Four-phase requesters: drop req once acked, re-raise only after ack falls.
    task automatic drive(input int raise_pct, input int drop_pct);
        if (req0) begin
            if (exp_ack(0) && $urandom_range(99) < drop_pct) req0 = 1'b0;
        end else if (!exp_ack(0) && $urandom_range(99) < raise_pct) begin
            req0  = 1'b1;
            addr0 = AW'($urandom_range(3));
            data0 = DW'($urandom_range(15));
        end
        if (req1) begin
            if (exp_ack(1) && $urandom_range(99) < drop_pct) req1 = 1'b0;
        end else if (!exp_ack(1) && $urandom_range(99) < raise_pct) begin
            req1  = 1'b1;
            addr1 = AW'($urandom_range(3));
            data1 = DW'($urandom_range(15));
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        tick("rst_hold");
        rst = 1'b1;
    endtask

    initial begin
        // Reset values
        #2;
        check_all("reset");
        chk("reset.ack0", 32'(ack0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("idle");

        // Single core write: addr 2, data A
        req0 = 1'b1; addr0 = 2'd2; data0 = 4'hA;
        tick("t1_write");
        chk("t1.we", 32'(bank_we), 32'd1);
        chk("t1.addr", 32'(bank_addr), 32'd2);
        chk("t1.data", 32'(bank_data), 32'hA);
        tick("t1_ack");
        chk("t1.ack0_rise", 32'(ack0), 32'd1);
        chk("t1.we_pulse", 32'(bank_we), 32'd0);
        tick("t1_ack_hold");
        req0 = 1'b0;
        tick("t1_clear");
        chk("t1.ack0_fall", 32'(ack0), 32'd0);
        chk("t1.state_clear", 32'(state_out), 32'd3);
        tick("t1_idle");

        // Simultaneous requests after reset: port 0 first, then port 1
        pulse_reset();
        req0 = 1'b1; addr0 = 2'd1; data0 = 4'h3;
        req1 = 1'b1; addr1 = 2'd3; data1 = 4'hC;
        tick("t2_write0");
        chk("t2.addr0", 32'(bank_addr), 32'd1);
        chk("t2.data0", 32'(bank_data), 32'h3);
        tick("t2_ack0");
        chk("t2.ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick("t2_clear0");
        tick("t2_idle");
        tick("t2_write1");
        chk("t2.we1", 32'(bank_we), 32'd1);
        chk("t2.addr1", 32'(bank_addr), 32'd3);
        chk("t2.data1", 32'(bank_data), 32'hC);
        tick("t2_ack1");
        chk("t2.ack1", 32'(ack1), 32'd1);
        req1 = 1'b0;
        tick("t2_clear1");
        tick("t2_idle1");

        // Continuous contention: grants must alternate
        pa0 = ack0; pa1 = ack1;
        for (int c = 0; c < 36; c++) begin
            drive(100, 100);
            tick("t3");
            if (ack0 && !pa0) grants.push_back(0);
            if (ack1 && !pa1) grants.push_back(1);
            pa0 = ack0; pa1 = ack1;
        end
        chk("t3.grant_count_ge8", 32'(grants.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++)
            if (i < grants.size()) chk($sformatf("t3.grant%0d", i), 32'(grants[i]), 32'(i % 2));
        for (int c = 0; c < 8; c++) begin
            drive(0, 100);
            tick("t3_drain");
        end

        // One-cycle debug pulse to R0
        req1 = 1'b1; addr1 = 2'd0; data1 = 4'hF;
        tick("t4_write");
        req1 = 1'b0;
        chk("t4.addr", 32'(bank_addr), 32'd0);
        chk("t4.data", 32'(bank_data), 32'hF);
        tick("t4_ack");
        chk("t4.ack1_on", 32'(ack1), 32'd1);
        tick("t4_clear");
        chk("t4.ack1_off", 32'(ack1), 32'd0);
        chk("t4.state_clear", 32'(state_out), 32'd3);
        tick("t4_idle");
        chk("t4.state_idle", 32'(state_out), 32'd0);

        // Reset during WRITE, then a fresh transaction with req0 held high
        req0 = 1'b1; addr0 = 2'd3; data0 = 4'h5;
        tick("t5_write");
        chk("t5.we_before", 32'(bank_we), 32'd1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t5.we_async", 32'(bank_we), 32'd0);
        check_all("t5_async");
        tick("t5_hold");
        rst = 1'b1;
        tick("t5_rewrite");
        chk("t5.rewrite_addr", 32'(bank_addr), 32'd3);
        tick("t5_ack");
        chk("t5.ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick("t5_clear");
        tick("t5_idle");

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(35, 60);
            tick("rand");
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 100);
            tick("rand_drain");
        end
        chk("end.idle", 32'(state_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
